// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the input/gameplay side and the game sequencer.
// The master side drives buttons and gameplay status; the sequencer drives the screen state.
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_help;
    logic       btn_staff;
    logic       btn_back;
    logic [1:0] key_find;
    logic [1:0] life;
    logic       at_door;
    logic [3:0] state;
    logic [5:0] shift;
    logic       stage_init;
    logic       hold_done;

    modport master (
        output frame_tick, btn_start, btn_help, btn_staff, btn_back,
        output key_find, life, at_door,
        input  state, shift, stage_init, hold_done
    );

    modport slave (
        input  frame_tick, btn_start, btn_help, btn_staff, btn_back,
        input  key_find, life, at_door,
        output state, shift, stage_init, hold_done
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: screen/game state, banner scroll offset, and the
// hold timer that paces SUCCESS/FAIL screens.
module game_flow_ctrl #(
    parameter int HOLD_FRAMES = 120,
    parameter int HOLD_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  gf
);

    typedef enum logic [3:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8,
        HELP     = 4'd9
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    // Kept as a plain 4-bit vector so codes 10-15 remain representable and recoverable.
    logic [3:0]        state_r;
    logic [3:0]        state_nxt;
    logic [5:0]        shift_r;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done_r;
    logic              stage_init_r;
    logic              start_q, help_q, staff_q, back_q;
    logic              rise_start, rise_help, rise_staff, rise_back;
    logic              changed;
    logic              nxt_is_stage;
    logic              all_keys;

    assign rise_start = gf.btn_start & ~start_q;
    assign rise_help  = gf.btn_help  & ~help_q;
    assign rise_staff = gf.btn_staff & ~staff_q;
    assign rise_back  = gf.btn_back  & ~back_q;
    assign all_keys   = (gf.key_find == 2'd3);

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            TITLE: begin
                if (rise_start)      state_nxt = STAGE1;
                else if (rise_help)  state_nxt = HELP;
                else if (rise_staff) state_nxt = STAFF;
            end
            HELP, STAFF: begin
                if (rise_back) state_nxt = TITLE;
            end
            // Death outranks reaching the door; a locked door is simply ignored.
            STAGE1: begin
                if (gf.life == 2'd0)             state_nxt = FAIL;
                else if (gf.at_door && all_keys) state_nxt = SUCCESS1;
            end
            STAGE2: begin
                if (gf.life == 2'd0)             state_nxt = FAIL;
                else if (gf.at_door && all_keys) state_nxt = SUCCESS2;
            end
            STAGE3: begin
                if (gf.life == 2'd0)             state_nxt = FAIL;
                else if (gf.at_door && all_keys) state_nxt = SUCCESS3;
            end
            SUCCESS1: if (hold_done_r) state_nxt = STAGE2;
            SUCCESS2: if (hold_done_r) state_nxt = STAGE3;
            SUCCESS3: if (hold_done_r) state_nxt = TITLE;
            FAIL:     if (hold_done_r && rise_start) state_nxt = TITLE;
            default:  state_nxt = TITLE;
        endcase
    end

    assign changed      = (state_nxt != state_r);
    assign nxt_is_stage = (state_nxt == STAGE1) || (state_nxt == STAGE2) || (state_nxt == STAGE3);

    // Button history resets high so a button held through reset cannot fire on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= TITLE;
            shift_r      <= 6'd0;
            hold_cnt     <= '0;
            hold_done_r  <= 1'b0;
            stage_init_r <= 1'b0;
            start_q      <= 1'b1;
            help_q       <= 1'b1;
            staff_q      <= 1'b1;
            back_q       <= 1'b1;
        end else begin
            start_q      <= gf.btn_start;
            help_q       <= gf.btn_help;
            staff_q      <= gf.btn_staff;
            back_q       <= gf.btn_back;
            state_r      <= state_nxt;
            stage_init_r <= changed && nxt_is_stage;
            // A state change clears both counters even if a frame tick lands on the same cycle.
            if (changed) begin
                shift_r     <= 6'd0;
                hold_cnt    <= '0;
                hold_done_r <= 1'b0;
            end else if (gf.frame_tick) begin
                shift_r <= shift_r + 6'd1;
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt    <= hold_cnt + 1'b1;
                    hold_done_r <= (hold_cnt == HOLD_MAX - 1'b1);
                end
            end
        end
    end

    assign gf.state      = state_r;
    assign gf.shift      = shift_r;
    assign gf.stage_init = stage_init_r;
    assign gf.hold_done  = hold_done_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a vector table for the opening sequence
// followed by hand-written multi-cycle scenarios.
module tb_game_flow_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    game_flow_ctrl_if gf ();

    game_flow_ctrl #(.HOLD_FRAMES(120), .HOLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .gf  (gf)
    );

    typedef struct {
        logic       start;
        logic       help;
        logic       staff;
        logic       back;
        logic [1:0] key;
        logic [1:0] life;
        logic       door;
        logic       tick;
        logic [3:0] e_state;
        logic       e_si;
        logic [5:0] e_shift;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            gf.frame_tick = 1'b1;
            cyc();
        end
        gf.frame_tick = 1'b0;
    endtask

    task automatic set_door(input logic [1:0] key, input logic door);
        gf.key_find = key;
        gf.at_door  = door;
    endtask

    initial begin
        gf.frame_tick = 1'b0;
        gf.btn_start  = 1'b1;
        gf.btn_help   = 1'b0;
        gf.btn_staff  = 1'b0;
        gf.btn_back   = 1'b0;
        gf.key_find   = 2'd0;
        gf.life       = 2'd3;
        gf.at_door    = 1'b0;

        //            start help staff back key  life  door tick  state si shift
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0, 6'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 4'd2, 1'b1, 6'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 4'd2, 1'b0, 6'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b1, 1'b0, 4'd2, 1'b0, 6'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, 4'd3, 1'b0, 6'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 4'd3, 1'b0, 6'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 4'd3, 1'b0, 6'd2};

        // Reset held across edges with btn_start pressed
        cyc();
        cyc();
        check("rst_state", gf.state, 4'd0);
        check("rst_shift", gf.shift, 6'd0);
        check("rst_stage_init", gf.stage_init, 1'b0);
        check("rst_hold_done", gf.hold_done, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            gf.btn_start  = vecs[i].start;
            gf.btn_help   = vecs[i].help;
            gf.btn_staff  = vecs[i].staff;
            gf.btn_back   = vecs[i].back;
            gf.key_find   = vecs[i].key;
            gf.life       = vecs[i].life;
            gf.at_door    = vecs[i].door;
            gf.frame_tick = vecs[i].tick;
            cyc();
            check($sformatf("vec%0d_state", i), gf.state, vecs[i].e_state);
            check($sformatf("vec%0d_stage_init", i), gf.stage_init, vecs[i].e_si);
            check($sformatf("vec%0d_shift", i), gf.shift, vecs[i].e_shift);
        end
        gf.frame_tick = 1'b0;

        // SUCCESS1 hold: two ticks already applied, 118 more reach the limit
        ticks(117);
        check("succ1_119_state", gf.state, 4'd3);
        check("succ1_119_hold_done", gf.hold_done, 1'b0);
        ticks(1);
        check("succ1_120_hold_done", gf.hold_done, 1'b1);
        check("succ1_120_state", gf.state, 4'd3);
        cyc();
        check("stage2_state", gf.state, 4'd4);
        check("stage2_stage_init", gf.stage_init, 1'b1);
        check("stage2_shift", gf.shift, 6'd0);
        check("stage2_hold_done", gf.hold_done, 1'b0);
        cyc();
        check("stage2_si_once", gf.stage_init, 1'b0);

        // Death and door with all keys in the same cycle
        gf.life = 2'd0;
        set_door(2'd3, 1'b1);
        cyc();
        check("fail_priority", gf.state, 4'd8);
        gf.life = 2'd3;
        set_door(2'd0, 1'b0);

        // FAIL: early start ignored, saturating hold, wrapping shift
        ticks(50);
        gf.btn_start = 1'b1;
        cyc();
        check("fail_early_start", gf.state, 4'd8);
        gf.btn_start = 1'b0;
        ticks(70);
        check("fail_hold_done", gf.hold_done, 1'b1);
        ticks(5);
        check("fail_hold_sat", gf.hold_done, 1'b1);
        check("fail_shift_wrap", gf.shift, 6'd61);
        gf.btn_start = 1'b1;
        cyc();
        check("fail_to_title", gf.state, 4'd0);
        check("fail_to_title_shift", gf.shift, 6'd0);
        gf.btn_start = 1'b0;

        // Menus
        gf.btn_help  = 1'b1;
        gf.btn_staff = 1'b1;
        cyc();
        check("help_wins", gf.state, 4'd9);
        gf.btn_back = 1'b1;
        cyc();
        check("help_back", gf.state, 4'd0);
        gf.btn_help  = 1'b0;
        gf.btn_staff = 1'b0;
        gf.btn_back  = 1'b0;
        cyc();
        check("title_idle", gf.state, 4'd0);
        gf.btn_staff = 1'b1;
        cyc();
        check("staff_enter", gf.state, 4'd1);
        gf.btn_back = 1'b1;
        cyc();
        check("staff_back", gf.state, 4'd0);
        gf.btn_staff = 1'b0;
        gf.btn_back  = 1'b0;
        ticks(70);
        check("title_shift70", gf.shift, 6'd6);
        check("title_hold70", gf.hold_done, 1'b0);
        ticks(60);
        check("title_hold130", gf.hold_done, 1'b1);
        check("title_shift130", gf.shift, 6'd2);

        // Illegal state code recovery
        force dut.state_r = 4'd12;
        #1;
        release dut.state_r;
        check("illegal_forced", gf.state, 4'd12);
        cyc();
        check("illegal_state", gf.state, 4'd0);
        check("illegal_shift", gf.shift, 6'd0);
        check("illegal_hold_done", gf.hold_done, 1'b0);

        // Reset in the middle of a stage
        gf.btn_start = 1'b1;
        cyc();
        check("mid_enter_state", gf.state, 4'd2);
        check("mid_enter_si", gf.stage_init, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_state", gf.state, 4'd0);
        check("mid_rst_si", gf.stage_init, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        check("mid_post_state", gf.state, 4'd0);
        check("mid_post_si", gf.stage_init, 1'b0);
        gf.btn_start = 1'b0;
        cyc();

        // Full run through all three stages back to TITLE
        gf.btn_start = 1'b1;
        cyc();
        check("run_stage1", gf.state, 4'd2);
        gf.btn_start = 1'b0;
        set_door(2'd3, 1'b1);
        cyc();
        check("run_success1", gf.state, 4'd3);
        set_door(2'd0, 1'b0);
        ticks(120);
        cyc();
        check("run_stage2", gf.state, 4'd4);
        check("run_stage2_si", gf.stage_init, 1'b1);
        set_door(2'd3, 1'b1);
        cyc();
        check("run_success2", gf.state, 4'd5);
        set_door(2'd0, 1'b0);
        ticks(120);
        cyc();
        check("run_stage3", gf.state, 4'd6);
        check("run_stage3_si", gf.stage_init, 1'b1);
        set_door(2'd3, 1'b1);
        cyc();
        check("run_success3", gf.state, 4'd7);
        set_door(2'd0, 1'b0);
        ticks(120);
        cyc();
        check("run_title", gf.state, 4'd0);
        check("run_title_si", gf.stage_init, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
